// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock divider: state encoding and
// the constants behind config validation and high-time clamping.
package clk_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_e;

    // Smallest divide ratio accepted; anything below is rejected with cfg_err.
    localparam int unsigned MIN_DIV     = 2;
    // Out-of-range high time is replaced by N >> CLAMP_SHIFT (50% duty, floor).
    localparam int unsigned CLAMP_SHIFT = 1;

endpackage

// File: rtl/clk_div.sv
// Programmable integer clock divider producing a registered divided waveform,
// edge strobes and a lock flag; new configs are applied on period boundaries.
module clk_div
    import clk_div_pkg::*;
#(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] cfg_div,
    input  logic [WIDTH-1:0] cfg_high,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             tick_rise,
    output logic             tick_fall,
    output logic             locked
);

    localparam logic [WIDTH-1:0] RST_DIV  = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] RST_HIGH = WIDTH'(DEFAULT_DIV >> CLAMP_SHIFT);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] high_q, high_d;
    logic [WIDTH-1:0] pend_div_q, pend_div_d;
    logic [WIDTH-1:0] pend_high_q, pend_high_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_rise_q, tick_rise_d;
    logic             tick_fall_q, tick_fall_d;
    logic             locked_q, locked_d;
    logic             cfg_err_q, cfg_err_d;
    logic             cfg_ready_q, cfg_ready_d;

    logic             cfg_hs;
    logic             cfg_bad;
    logic             cfg_ok;
    logic             wrap;
    logic [WIDTH-1:0] cfg_high_clamped;

    assign cfg_hs           = cfg_valid & cfg_ready_q;
    assign cfg_bad          = (cfg_div < WIDTH'(MIN_DIV));
    assign cfg_ok           = cfg_hs & ~cfg_bad;
    assign cfg_high_clamped = ((cfg_high == '0) || (cfg_high >= cfg_div))
                              ? (cfg_div >> CLAMP_SHIFT) : cfg_high;
    assign wrap             = (cnt_q == (div_q - WIDTH'(1)));

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        div_d       = div_q;
        high_d      = high_q;
        pend_div_d  = pend_div_q;
        pend_high_d = pend_high_q;
        clk_out_d   = clk_out_q;
        locked_d    = locked_q;
        cfg_err_d   = cfg_hs & cfg_bad;

        case (state_q)
            ST_IDLE: begin
                cnt_d     = '0;
                clk_out_d = 1'b0;
                locked_d  = 1'b0;
                if (cfg_ok) begin
                    div_d  = cfg_div;
                    high_d = cfg_high_clamped;
                end
                if (en) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN, ST_PEND: begin
                if (!en) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    clk_out_d = 1'b0;
                    locked_d  = 1'b0;
                    if (state_q == ST_PEND) begin
                        div_d  = pend_div_q;
                        high_d = pend_high_q;
                    end else if (cfg_ok) begin
                        div_d  = cfg_div;
                        high_d = cfg_high_clamped;
                    end
                end else begin
                    clk_out_d = (cnt_q < high_q);
                    cnt_d     = wrap ? '0 : (cnt_q + WIDTH'(1));
                    if (wrap) begin
                        locked_d = 1'b1;
                        // Swap config only at the boundary so no runt pulse appears
                        if (state_q == ST_PEND) begin
                            div_d    = pend_div_q;
                            high_d   = pend_high_q;
                            locked_d = 1'b0;
                            state_d  = ST_RUN;
                        end
                    end
                    // A request landing on a wrap waits for the following one
                    if (cfg_ok) begin
                        pend_div_d  = cfg_div;
                        pend_high_d = cfg_high_clamped;
                        state_d     = ST_PEND;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        tick_rise_d = clk_out_d & ~clk_out_q;
        tick_fall_d = ~clk_out_d & clk_out_q;
        cfg_ready_d = (state_d != ST_PEND);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            div_q       <= RST_DIV;
            high_q      <= RST_HIGH;
            pend_div_q  <= RST_DIV;
            pend_high_q <= RST_HIGH;
            clk_out_q   <= 1'b0;
            tick_rise_q <= 1'b0;
            tick_fall_q <= 1'b0;
            locked_q    <= 1'b0;
            cfg_err_q   <= 1'b0;
            cfg_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            high_q      <= high_d;
            pend_div_q  <= pend_div_d;
            pend_high_q <= pend_high_d;
            clk_out_q   <= clk_out_d;
            tick_rise_q <= tick_rise_d;
            tick_fall_q <= tick_fall_d;
            locked_q    <= locked_d;
            cfg_err_q   <= cfg_err_d;
            cfg_ready_q <= cfg_ready_d;
        end
    end

    assign clk_out   = clk_out_q;
    assign tick_rise = tick_rise_q;
    assign tick_fall = tick_fall_q;
    assign locked    = locked_q;
    assign cfg_err   = cfg_err_q;
    assign cfg_ready = cfg_ready_q;

endmodule

// File: tb/tb_clk_div.sv
// Self-checking bench for clk_div: directed scenarios plus random traffic,
// all compared against a period/phase model of the divider.
module tb_clk_div;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         cfg_valid = 1'b0;
    logic [W-1:0] cfg_div = '0;
    logic [W-1:0] cfg_high = '0;
    logic         cfg_ready, cfg_err, clk_out, tick_rise, tick_fall, locked;
    logic [5:0]   obs;

    int total = 0;
    int bad   = 0;

    assign obs = {clk_out, tick_rise, tick_fall, locked, cfg_err, cfg_ready};

    always #5 clk = ~clk;

    clk_div #(.WIDTH(W), .DEFAULT_DIV(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .cfg_div   (cfg_div),
        .cfg_high  (cfg_high),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .clk_out   (clk_out),
        .tick_rise (tick_rise),
        .tick_fall (tick_fall),
        .locked    (locked)
    );

    // Reference model: running flag, elapsed cycles in the current config
    // segment, and the phase derived from it by modulo arithmetic.
    bit m_run, m_pend;
    int m_el, m_n, m_h, m_pn, m_ph;
    bit e_clk, e_rise, e_fall, e_lock, e_err, e_rdy;

    function automatic logic [5:0] expv();
        return {e_clk, e_rise, e_fall, e_lock, e_err, e_rdy};
    endfunction

    function automatic void model_reset();
        m_run = 0; m_pend = 0; m_el = 0; m_n = 2; m_h = 1; m_pn = 0; m_ph = 0;
        e_clk = 0; e_rise = 0; e_fall = 0; e_lock = 0; e_err = 0; e_rdy = 1;
    endfunction

    function automatic void model_step(input bit e, input bit v, input int d, input int h);
        bit hs, bd, nclk;
        int eh, phase;
        hs    = v && e_rdy;
        bd    = hs && (d < 2);
        eh    = (h == 0 || h >= d) ? d / 2 : h;
        e_err = bd;
        nclk  = 0;
        if (!m_run) begin
            if (hs && !bd) begin m_n = d; m_h = eh; end
            if (e) begin m_run = 1; m_el = 0; end
            e_lock = 0;
        end else if (!e) begin
            if (m_pend) begin m_n = m_pn; m_h = m_ph; m_pend = 0; end
            else if (hs && !bd) begin m_n = d; m_h = eh; end
            m_run  = 0;
            e_lock = 0;
        end else begin
            phase = m_el % m_n;
            nclk  = (phase < m_h);
            m_el++;
            if (phase == m_n - 1) begin
                if (m_pend) begin
                    m_n = m_pn; m_h = m_ph; m_pend = 0; m_el = 0; e_lock = 0;
                end else begin
                    e_lock = 1;
                end
            end
            if (hs && !bd) begin m_pend = 1; m_pn = d; m_ph = eh; end
        end
        e_rise = nclk && !e_clk;
        e_fall = !nclk && e_clk;
        e_clk  = nclk;
        e_rdy  = !m_pend;
    endfunction

    // Drive one cycle of inputs, advance the model, land 1 time unit after the edge
    task automatic cycle(input bit e, input bit v, input int d, input int h);
        en = e; cfg_valid = v; cfg_div = W'(d); cfg_high = W'(h);
        @(posedge clk);
        model_step(e, v, d, h);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        if (obs !== 6'b000001) begin bad++; $display("FAIL reset_hold got=%b want=%b", obs, 6'b000001); end
        total++;
        rst_n = 1'b1;
        cycle(0, 0, 0, 0);
        if (obs !== expv()) begin bad++; $display("FAIL reset_idle got=%b want=%b", obs, expv()); end
        total++;
    endtask

    task automatic test_default();
        cycle(1, 0, 0, 0);
        if (obs !== expv() || clk_out !== 1'b0) begin bad++; $display("FAIL default_enter got=%b want=%b", obs, expv()); end
        total++;
        for (int i = 0; i < 8; i++) begin
            cycle(1, 0, 0, 0);
            if (clk_out !== 1'(i % 2 == 0) || locked !== 1'(i >= 1)) begin
                bad++; $display("FAIL default_wave i=%0d got clk=%b lock=%b want clk=%b lock=%b", i, clk_out, locked, (i % 2 == 0), (i >= 1));
            end
            total++;
            if (obs !== expv()) begin bad++; $display("FAIL default_model i=%0d got=%b want=%b", i, obs, expv()); end
            total++;
        end
    endtask

    task automatic test_cfg_n5();
        bit pat [5] = '{1, 1, 0, 0, 0};
        bit seen;
        cycle(1, 1, 5, 2);
        if (cfg_ready !== 1'b0) begin bad++; $display("FAIL n5_ready_low got=%b want=0", cfg_ready); end
        total++;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cycle(1, 0, 0, 0);
            if (obs !== expv()) begin bad++; $display("FAIL n5_pend i=%0d got=%b want=%b", i, obs, expv()); end
            total++;
            seen = cfg_ready;
        end
        if (!seen) begin bad++; $display("FAIL n5_ready_timeout got=0 want=1"); end
        total++;
        if (locked !== 1'b0) begin bad++; $display("FAIL n5_lock_clear got=%b want=0", locked); end
        total++;
        for (int i = 1; i <= 10; i++) begin
            cycle(1, 0, 0, 0);
            if (clk_out !== pat[(i - 1) % 5] || locked !== 1'(i >= 5)) begin
                bad++; $display("FAIL n5_wave i=%0d got clk=%b lock=%b want clk=%b lock=%b", i, clk_out, locked, pat[(i - 1) % 5], (i >= 5));
            end
            total++;
            if (obs !== expv()) begin bad++; $display("FAIL n5_model i=%0d got=%b want=%b", i, obs, expv()); end
            total++;
        end
    endtask

    task automatic test_cfg_err();
        cycle(1, 1, 1, 0);
        if (cfg_err !== 1'b1 || cfg_ready !== 1'b1) begin bad++; $display("FAIL err_pulse got err=%b rdy=%b want err=1 rdy=1", cfg_err, cfg_ready); end
        total++;
        cycle(1, 0, 0, 0);
        if (cfg_err !== 1'b0) begin bad++; $display("FAIL err_one_cycle got=%b want=0", cfg_err); end
        total++;
        for (int i = 0; i < 6; i++) begin
            cycle(1, 0, 0, 0);
            if (obs !== expv()) begin bad++; $display("FAIL err_wave i=%0d got=%b want=%b", i, obs, expv()); end
            total++;
        end
    endtask

    task automatic test_clamp();
        bit pat [6] = '{1, 1, 1, 0, 0, 0};
        cycle(0, 0, 0, 0);
        cycle(0, 1, 6, 9);
        cycle(1, 0, 0, 0);
        if (obs !== expv()) begin bad++; $display("FAIL clamp_enter got=%b want=%b", obs, expv()); end
        total++;
        for (int i = 0; i < 12; i++) begin
            cycle(1, 0, 0, 0);
            if (clk_out !== pat[i % 6]) begin bad++; $display("FAIL clamp_wave i=%0d got=%b want=%b", i, clk_out, pat[i % 6]); end
            total++;
            if (obs !== expv()) begin bad++; $display("FAIL clamp_model i=%0d got=%b want=%b", i, obs, expv()); end
            total++;
        end
    endtask

    task automatic test_en_drop();
        bit seen;
        seen = 0;
        for (int i = 0; i < 12 && !seen; i++) begin
            cycle(1, 0, 0, 0);
            seen = clk_out;
        end
        if (!seen) begin bad++; $display("FAIL drop_wait_high got=0 want=1"); end
        total++;
        cycle(0, 0, 0, 0);
        if (clk_out !== 1'b0 || tick_fall !== 1'b1) begin bad++; $display("FAIL drop_fall got clk=%b fall=%b want clk=0 fall=1", clk_out, tick_fall); end
        total++;
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 0);
            if (obs !== 6'b000001) begin bad++; $display("FAIL drop_idle i=%0d got=%b want=%b", i, obs, 6'b000001); end
            total++;
        end
    endtask

    task automatic test_reset_pending();
        cycle(1, 0, 0, 0);
        repeat (2) cycle(1, 0, 0, 0);
        cycle(1, 1, 5, 2);
        if (cfg_ready !== 1'b0) begin bad++; $display("FAIL rstp_pend got=%b want=0", cfg_ready); end
        total++;
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        if (obs !== 6'b000001) begin bad++; $display("FAIL rstp_async got=%b want=%b", obs, 6'b000001); end
        total++;
        @(posedge clk);
        #1 rst_n = 1'b1;
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            cycle(1, 0, 0, 0);
            if (clk_out !== 1'(i % 2 == 0)) begin bad++; $display("FAIL rstp_default i=%0d got=%b want=%b", i, clk_out, (i % 2 == 0)); end
            total++;
            if (obs !== expv()) begin bad++; $display("FAIL rstp_model i=%0d got=%b want=%b", i, obs, expv()); end
            total++;
        end
    endtask

    task automatic test_max_div();
        cycle(0, 0, 0, 0);
        cycle(0, 1, 65535, 65535);
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cycle(1, 0, 0, 0);
            if (obs !== expv()) begin bad++; $display("FAIL maxdiv i=%0d got=%b want=%b", i, obs, expv()); end
            total++;
        end
        cycle(0, 0, 0, 0);
    endtask

    task automatic test_random();
        bit e, v;
        int d, h;
        for (int i = 0; i < 800; i++) begin
            e = ($urandom_range(0, 19) != 0);
            v = ($urandom_range(0, 6) == 0);
            d = int'($urandom_range(0, 9));
            h = int'($urandom_range(0, 11));
            cycle(e, v, d, h);
            if (obs !== expv()) begin bad++; $display("FAIL random i=%0d got=%b want=%b", i, obs, expv()); end
            total++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_default();
        test_cfg_n5();
        test_cfg_err();
        test_clamp();
        test_en_drop();
        test_reset_pending();
        test_max_div();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clk_div.md
CLK_DIV -- requirements
Module: clk_div

Interface
REQ-001 Parameter WIDTH, default 16, bit width of divide-ratio and high-time fields.
REQ-002 Parameter DEFAULT_DIV, default 2, divide ratio loaded at reset.
REQ-003 clk  input  1  single system clock (the PLL c0 output); all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 en  input  1  run enable; 0 parks the divider.
REQ-006 cfg_div  input  WIDTH  requested divide ratio N.
REQ-007 cfg_high  input  WIDTH  requested high time H in clk cycles.
REQ-008 cfg_valid  input  1  config request.
REQ-009 cfg_ready  output  1  config accepted when cfg_valid and cfg_ready both 1.
REQ-010 cfg_err  output  1  one-cycle pulse: accepted config rejected (N<2).
REQ-011 clk_out  output  1  registered divided waveform, period N, high H cycles.
REQ-012 tick_rise  output  1  one-cycle strobe, coincident with the cycle clk_out goes 0->1.
REQ-013 tick_fall  output  1  one-cycle strobe, coincident with the cycle clk_out goes 1->0.
REQ-014 locked  output  1  1 once a full period has completed with the active config.

Function
REQ-015 States: IDLE (en=0), RUN, PEND (accepted config waiting for period boundary).
REQ-016 IDLE: cnt=0, clk_out=0, no ticks, locked=0; en=1 -> RUN next cycle, cnt starts at 0.
REQ-017 RUN: cnt counts 0..N-1 and wraps to 0; clk_out=1 when cnt<H, else 0.
REQ-018 clk_out is registered: first high cycle is the cycle after entering RUN; no combinational path from inputs to clk_out.
REQ-019 cfg_ready=1 in IDLE and RUN, 0 in PEND.
REQ-020 Handshake with N<2: config discarded, cfg_err=1 for exactly one cycle, state unchanged.
REQ-021 Handshake with H=0 or H>=N: H clamped to N>>1 (floor); no error.
REQ-022 Accepted valid config in IDLE applies immediately; in RUN -> PEND, stored, applied on the cycle cnt wraps to 0 (glitch-free), then -> RUN.
REQ-023 Config application clears locked; locked sets on the next wrap of cnt to 0.
REQ-024 en falling in RUN or PEND: -> IDLE next cycle, clk_out=0; emits tick_fall if clk_out was 1; pending config applied immediately.
REQ-025 cfg_valid and wrap in the same cycle while RUN: new config applies at the following wrap, not the current one.
REQ-026 N=2, H=1: clk_out toggles every cycle; tick_rise/tick_fall alternate.
REQ-027 Counter compares unsigned, WIDTH bits; N=2^WIDTH-1 supported, no overflow.

Reset
REQ-028 While rst_n=0: state=IDLE, cnt=0, N=DEFAULT_DIV, H=DEFAULT_DIV>>1, clk_out=0, ticks=0, locked=0, cfg_err=0, cfg_ready=1.
REQ-029 Reset mid-operation discards any pending config; deassertion resumes in IDLE.

Structure
REQ-030 State encoding (IDLE/RUN/PEND) and clamp rule constant live in shared package clk_div_pkg.
REQ-031 Single module; no sub-modules; all outputs driven from flops.

Verification
REQ-032 Reset, en=1, defaults N=2,H=1 -> clk_out 0,1,0,1..., first high cycle 1 after en, locked after 2 cycles.
REQ-033 Config N=5,H=2 in RUN mid-period -> cfg_ready low until wrap; then clk_out pattern 1,1,0,0,0 repeating; locked low for exactly one period.
REQ-034 Config N=1 -> cfg_err one-cycle pulse, waveform unchanged, cfg_ready stays 1.
REQ-035 Config N=6,H=9 -> H clamped to 3, pattern 1,1,1,0,0,0.
REQ-036 en dropped while clk_out=1 -> tick_fall same cycle clk_out goes 0, state IDLE, no further ticks.
REQ-037 rst_n asserted with config pending -> all outputs reset values immediately; after release and en=1, N=DEFAULT_DIV.
